cp_inserter_pp: RTL and testbench

//  Parametrised cyclic-prefix inserter for the OFDM TX chain, placed after the IFFT.

---
 rtl/cp_inserter_pp_pkg.sv | 20 ++
 rtl/cp_inserter_pp_if.sv | 31 +++
 rtl/cp_inserter_pp_dpram.sv | 20 ++
 rtl/cp_inserter_pp.sv | 157 +++++++++++++++
 tb/tb_cp_inserter_pp.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_inserter_pp_pkg.sv
// rtl/cp_inserter_pp_pkg.sv - shared types, defaults and FSM encodings for the CP inserter
package cp_inserter_pp_pkg;

  localparam int DW_DEF     = 16;
  localparam int N_LOG2_DEF = 10;
  localparam int CP_W_DEF   = 9;

  typedef struct packed {
    logic signed [DW_DEF-1:0] i;
    logic signed [DW_DEF-1:0] q;
  } cx_sample_t;

  localparam logic W_IDLE = 1'b0;
  localparam logic W_FILL = 1'b1;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_PREFIX = 2'd1;
  localparam logic [1:0] R_BODY   = 2'd2;

endpackage

// File: rtl/cp_inserter_pp_if.sv
// rtl/cp_inserter_pp_if.sv - sample-in / sample-out handshake bundle for the CP inserter
interface cp_inserter_pp_if
  import cp_inserter_pp_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CP_W = CP_W_DEF
);
  logic [CP_W-1:0]      cp_len;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sop;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sop;
  logic                 out_eop;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic                 err_sop;

  modport master (
    output cp_len, in_valid, in_sop, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_i, out_q, err_sop
  );

  modport slave (
    input  cp_len, in_valid, in_sop, in_i, in_q, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_i, out_q, err_sop
  );
endinterface

// File: rtl/cp_inserter_pp_dpram.sv
// rtl/cp_inserter_pp_dpram.sv - simple dual-port RAM, registered read that holds when not enabled
module cp_inserter_pp_dpram #(
  parameter int AW = 11,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cp_inserter_pp.sv
// rtl/cp_inserter_pp.sv - cyclic-prefix inserter over a two-bank ping-pong symbol buffer
module cp_inserter_pp
  import cp_inserter_pp_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int CP_W   = CP_W_DEF
) (
  input logic             clk,
  input logic             rst,
  cp_inserter_pp_if.slave bus
);
  localparam int                N      = 1 << N_LOG2;
  localparam logic [CP_W-1:0]   CP_MAX = CP_W'(N / 4);
  localparam logic [N_LOG2-1:0] LAST   = '1;

  logic              w_state;
  logic              w_bank;
  logic [N_LOG2-1:0] w_addr;
  logic [1:0]        bank_full;
  logic [CP_W-1:0]   cp_eff [2];
  logic              err_q;

  logic [1:0]        r_state;
  logic              r_bank;
  logic [N_LOG2-1:0] r_addr;

  logic              p1_valid, p1_sop, p1_eop;
  logic              out_valid_q, out_sop_q, out_eop_q;
  logic [2*DW-1:0]   out_data, rd_data;

  logic              in_beat, wr_en, w_done;
  logic              adv, rd_issue, in_pfx, rd_sop, rd_last, r_free;
  logic [N_LOG2-1:0] wr_addr, rd_addr, cp_ext;

  assign bus.in_ready = ~bank_full[w_bank];
  assign in_beat      = bus.in_valid & bus.in_ready;

  always_comb begin
    wr_en   = in_beat & (bus.in_sop | (w_state == W_FILL));
    wr_addr = bus.in_sop ? '0 : w_addr;
    w_done  = wr_en & ~bus.in_sop & (w_addr == LAST);
  end

  // A sop beat always restarts the fill at addr 0; mid-fill it also flags the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      w_bank    <= 1'b0;
      w_addr    <= '0;
      cp_eff[0] <= '0;
      cp_eff[1] <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= in_beat & bus.in_sop & (w_state == W_FILL);
      if (in_beat && bus.in_sop) begin
        w_state        <= W_FILL;
        w_addr         <= N_LOG2'(1);
        cp_eff[w_bank] <= (bus.cp_len > CP_MAX) ? CP_MAX : bus.cp_len;
      end else if (w_done) begin
        w_state <= W_IDLE;
        w_bank  <= ~w_bank;
        w_addr  <= '0;
      end else if (wr_en) begin
        w_addr <= w_addr + N_LOG2'(1);
      end
    end
  end

  // Writer only targets an empty bank and reader only frees a full one, so indices never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= '0;
    end else begin
      if (w_done) bank_full[w_bank] <= 1'b1;
      if (r_free) bank_full[r_bank] <= 1'b0;
    end
  end

  assign adv = ~out_valid_q | bus.out_ready;

  // R_IDLE issues the first read itself, so a waiting full bank costs no bubble.
  always_comb begin
    cp_ext   = N_LOG2'(cp_eff[r_bank]);
    rd_addr  = r_addr;
    in_pfx   = (r_state == R_PREFIX);
    rd_sop   = 1'b0;
    if (r_state == R_IDLE) begin
      rd_sop  = 1'b1;
      in_pfx  = (cp_ext != '0);
      rd_addr = -cp_ext;
    end
    rd_last  = ~in_pfx & (rd_addr == LAST);
    rd_issue = (~p1_valid | adv) & ((r_state != R_IDLE) | bank_full[r_bank]);
    r_free   = rd_issue & rd_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_bank  <= 1'b0;
      r_addr  <= '0;
    end else if (rd_issue) begin
      if (rd_last) begin
        r_state <= R_IDLE;
        r_bank  <= ~r_bank;
      end else begin
        r_state <= (in_pfx && rd_addr != LAST) ? R_PREFIX : R_BODY;
      end
      r_addr <= rd_addr + N_LOG2'(1);
    end
  end

  cp_inserter_pp_dpram #(.AW(N_LOG2 + 1), .W(2 * DW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({w_bank, wr_addr}),
    .wdata ({bus.in_i, bus.in_q}),
    .re    (rd_issue),
    .raddr ({r_bank, rd_addr}),
    .rdata (rd_data)
  );

  // p1 tracks the RAM read register; the RAM only re-reads when p1 is consumed or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid    <= 1'b0;
      p1_sop      <= 1'b0;
      p1_eop      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data    <= '0;
    end else begin
      if (rd_issue) begin
        p1_valid <= 1'b1;
        p1_sop   <= rd_sop;
        p1_eop   <= rd_last;
      end else if (adv) begin
        p1_valid <= 1'b0;
      end
      if (adv) begin
        out_valid_q <= p1_valid;
        out_sop_q   <= p1_valid & p1_sop;
        out_eop_q   <= p1_valid & p1_eop;
        out_data    <= p1_valid ? rd_data : '0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_i     = out_data[2*DW-1:DW];
  assign bus.out_q     = out_data[DW-1:0];
  assign bus.err_sop   = err_q;
endmodule

// File: tb/tb_cp_inserter_pp.sv
// tb/tb_cp_inserter_pp.sv - scoreboard bench for cp_inserter_pp against a symbol-level model
module tb_cp_inserter_pp;
  import cp_inserter_pp_pkg::*;

  localparam int DW = 16, N_LOG2 = 10, CP_W = 9;
  localparam int N = 1 << N_LOG2, CP_MAX = N / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp_inserter_pp_if #(.DW(DW), .CP_W(CP_W)) bus ();

  cp_inserter_pp #(.DW(DW), .N_LOG2(N_LOG2), .CP_W(CP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { cx_sample_t s; logic sop; logic eop; } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  cx_sample_t m_buf[$];
  bit         m_active = 0;
  int         m_cp = 0, m_err = 0;

  int errors = 0, checks = 0;
  int cyc = 0;
  int beats = 0, first_cyc = -1, last_cyc = -1, err_cycles = 0;
  int stall_cycles = 0, acc_cyc = 0;
  bit rnd_ready = 0;
  bit hold_pend = 0;
  logic [2*DW+1:0] hold_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Symbol-level reference: keep the samples since the last sop, emit tail+whole once N are held.
  task automatic model_beat(input bit sop, input cx_sample_t s, input int cp);
    if (sop) begin
      if (m_active) m_err++;
      m_active = 1;
      m_buf.delete();
      m_cp = (cp > CP_MAX) ? CP_MAX : cp;
    end else if (!m_active) begin
      return;
    end
    m_buf.push_back(s);
    if (m_buf.size() == N) begin
      for (int k = N - m_cp; k < N; k++)
        exp_q.push_back('{m_buf[k], k == N - m_cp, 1'b0});
      for (int k = 0; k < N; k++)
        exp_q.push_back('{m_buf[k], (m_cp == 0) && (k == 0), k == N - 1});
      m_active = 0;
    end
  endtask

  task automatic send_beat(input bit sop, input logic [15:0] iv, input int cp);
    cx_sample_t s;
    int guard = 0;
    s.i = iv;
    s.q = 16'($urandom);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_i     = s.i;
    bus.in_q     = s.q;
    bus.cp_len   = CP_W'(cp);
    while (!bus.in_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
      stall_cycles++;
    end
    if (guard >= 5000) begin
      chk("in_ready_timeout", 64'(guard), 0);
    end else begin
      acc_cyc = cyc;
      model_beat(sop, s, cp);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  // cp_len is scrambled after the sop beat; only the value at sop may matter.
  task automatic send_symbol(input int cp, input int base);
    for (int k = 0; k < N; k++)
      send_beat(k == 0, 16'(base + k), (k == 0) ? cp : int'($urandom_range(0, 511)));
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_stats();
    beats = 0; first_cyc = -1; last_cyc = -1;
    err_cycles = 0; m_err = 0; stall_cycles = 0;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.err_sop) err_cycles++;
      if (hold_pend) begin
        checks++;
        if (!bus.out_valid ||
            {bus.out_sop, bus.out_eop, bus.out_i, bus.out_q} !== hold_val) begin
          errors++;
          $display("FAIL hold: got valid=%0b data=%h expected valid=1 data=%h",
                   bus.out_valid, {bus.out_sop, bus.out_eop, bus.out_i, bus.out_q}, hold_val);
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_sop, bus.out_eop, bus.out_i, bus.out_q};
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got i=%0d q=%0d sop=%0b eop=%0b expected no output",
                   bus.out_i, bus.out_q, bus.out_sop, bus.out_eop);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.out_i, bus.out_q, bus.out_sop, bus.out_eop} !==
              {mon_e.s.i, mon_e.s.q, mon_e.sop, mon_e.eop}) begin
            errors++;
            $display("FAIL out_beat: got i=%0d q=%0d sop=%0b eop=%0b expected i=%0d q=%0d sop=%0b eop=%0b",
                     bus.out_i, bus.out_q, bus.out_sop, bus.out_eop,
                     mon_e.s.i, mon_e.s.q, mon_e.sop, mon_e.eop);
          end
        end
      end
    end else begin
      hold_pend = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int guard;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_i     = '0;
    bus.in_q     = '0;
    bus.cp_len   = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_flags", {bus.out_sop, bus.out_eop, bus.err_sop}, 0);
    chk("rst_out_data", {bus.out_i, bus.out_q}, 0);
    rst = 1'b0;

    // 1: non-sop beats in idle are dropped, then ramp with cp=32
    reset_stats();
    for (int k = 0; k < 3; k++) send_beat(1'b0, 16'hdead, 32);
    send_symbol(32, 0);
    wait_drain("t1");
    chk("t1_beats", 64'(beats), N + 32);
    chk("t1_latency", 64'(first_cyc - (acc_cyc + 1)), 2);

    // 2: back-to-back 32/0/256, contiguous output, writer throttled
    reset_stats();
    send_symbol(32, 0);
    send_symbol(0, 0);
    send_symbol(256, 0);
    wait_drain("t2");
    chk("t2_beats", 64'(beats), 3 * N + 32 + 256);
    chk("t2_no_gap", 64'(last_cyc - first_cyc + 1), 3 * N + 32 + 256);
    chk("t2_in_ready_low", 64'(stall_cycles > 0), 1);

    // 3: random backpressure
    reset_stats();
    rnd_ready = 1;
    send_symbol(32, 0);
    wait_drain("t3");
    rnd_ready = 0;
    chk("t3_beats", 64'(beats), N + 32);

    // 4: second sop at addr 500 restarts the fill
    reset_stats();
    for (int k = 0; k < 500; k++) send_beat(k == 0, 16'(2000 + k), 64);
    send_symbol(16, 4000);
    wait_drain("t4");
    chk("t4_err_pulses", 64'(err_cycles), 64'(m_err));
    chk("t4_beats", 64'(beats), N + 16);

    // 5: prefix length clipped to N/4
    reset_stats();
    send_symbol(300, 0);
    wait_drain("t5");
    chk("t5_beats", 64'(beats), N + CP_MAX);

    // 6: reset while emitting the prefix
    reset_stats();
    send_symbol(32, 0);
    guard = 0;
    while (beats < 10 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_reach_prefix", 64'(beats >= 10), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_out_flags", {bus.out_sop, bus.out_eop, bus.err_sop}, 0);
    chk("t6_rst_out_data", {bus.out_i, bus.out_q}, 0);
    chk("t6_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    m_active = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_stats();
    send_symbol(64, 7000);
    wait_drain("t6");
    chk("t6_beats", 64'(beats), N + 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
